// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display output stage:
// conversion FSM states, seven-segment glyphs (active-low {g,f,e,d,c,b,a}).
package calc_pkg;

   typedef enum logic {
      OCIOSO   = 1'b0,
      CONVERTE = 1'b1
   } estado_t;

   localparam int unsigned BCD_W = 12;

   localparam logic [6:0] SEG_0       = 7'b1000000;
   localparam logic [6:0] SEG_1       = 7'b1111001;
   localparam logic [6:0] SEG_2       = 7'b0100100;
   localparam logic [6:0] SEG_3       = 7'b0110000;
   localparam logic [6:0] SEG_4       = 7'b0011001;
   localparam logic [6:0] SEG_5       = 7'b0010010;
   localparam logic [6:0] SEG_6       = 7'b0000010;
   localparam logic [6:0] SEG_7       = 7'b1111000;
   localparam logic [6:0] SEG_8       = 7'b0000000;
   localparam logic [6:0] SEG_9       = 7'b0010000;
   localparam logic [6:0] SEG_APAGADO = 7'b1111111;

   function automatic logic [6:0] seg_decode(input logic [3:0] digito);
      logic [6:0] s;
      case (digito)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_APAGADO;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/calc_display_if.sv
// Result bus between the calculator ALU (master) and the display stage (slave).
interface calc_display_if;
   import calc_pkg::*;

   logic [7:0]       resultado;
   logic             carregar;
   logic             ocupado;
   logic [BCD_W-1:0] bcd;
   logic             bcd_valido;

   modport master (
      output resultado, carregar,
      input  ocupado, bcd, bcd_valido
   );

   modport slave (
      input  resultado, carregar,
      output ocupado, bcd, bcd_valido
   );

endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: one shift per clock, bcd loaded and pulsed valid
// only after the final shift so the display never sees partial results.
module calc_bin2bcd
   import calc_pkg::*;
#(
   parameter int unsigned LARGURA = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               carregar,
   input  logic [LARGURA-1:0] resultado,
   output logic               ocupado,
   output logic [BCD_W-1:0]   bcd,
   output logic               bcd_valido
);

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] sr_q, sr_d;
   logic [BCD_W-1:0]   acc_q, acc_d, acc_aj;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               valido_q, valido_d;

   always_comb begin
      acc_aj = acc_q;
      for (int unsigned i = 0; i < BCD_W / 4; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5)
            acc_aj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      estado_d = estado_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      valido_d = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (carregar) begin
               sr_d     = resultado;
               acc_d    = '0;
               cnt_d    = '0;
               estado_d = CONVERTE;
            end
         end
         CONVERTE: begin
            {acc_d, sr_d} = {acc_aj, sr_q} << 1;
            cnt_d         = cnt_q + 4'd1;
            if (cnt_q == 4'(LARGURA - 1)) begin
               bcd_d    = {acc_aj[BCD_W-2:0], sr_q[LARGURA-1]};
               valido_d = 1'b1;
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= OCIOSO;
         sr_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         valido_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         sr_q     <= sr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         valido_q <= valido_d;
      end
   end

   assign ocupado    = (estado_q == CONVERTE);
   assign bcd        = bcd_q;
   assign bcd_valido = valido_q;

endmodule

// File: rtl/calc_display.sv
// 3-digit multiplexed common-anode display fed by the calculator result bus.
// Optional leading-zero blanking: define CALC_DISPLAY_SUPRIME_ZEROS_EN.
module calc_display
   import calc_pkg::*;
#(
   parameter int unsigned DIV_VARREDURA = 50000,
   parameter int unsigned LARGURA       = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   calc_display_if.slave  calc_if,
   output logic [6:0]     seg,
   output logic [2:0]     an
);

   localparam int unsigned    CNT_W   = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_VARREDURA - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [2:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       digito;

   calc_bin2bcd #(
      .LARGURA(LARGURA)
   ) u_bin2bcd (
      .clk        (clk),
      .rst_n      (rst_n),
      .carregar   (calc_if.carregar),
      .resultado  (calc_if.resultado),
      .ocupado    (calc_if.ocupado),
      .bcd        (calc_if.bcd),
      .bcd_valido (calc_if.bcd_valido)
   );

   // seg is re-decoded every cycle from the upcoming index, so a new bcd
   // appears one clock after it is latched and digit changes align with an.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end

      case (idx_d)
         2'd0:    begin an_d = 3'b110; digito = calc_if.bcd[3:0];  end
         2'd1:    begin an_d = 3'b101; digito = calc_if.bcd[7:4];  end
         default: begin an_d = 3'b011; digito = calc_if.bcd[11:8]; end
      endcase

      seg_d = seg_decode(digito);
`ifdef CALC_DISPLAY_SUPRIME_ZEROS_EN
      if (idx_d == 2'd2 && calc_if.bcd[11:8] == 4'd0)
         seg_d = SEG_APAGADO;
      if (idx_d == 2'd1 && calc_if.bcd[11:4] == 8'd0)
         seg_d = SEG_APAGADO;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
         an_q  <= 3'b110;
         seg_q <= SEG_0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_calc_display.sv
// Randomized self-checking bench for calc_display against a decimal-arithmetic
// reference model; honours CALC_DISPLAY_SUPRIME_ZEROS_EN like the design.
module tb_calc_display;

   localparam int unsigned DIV = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] seg;
   logic [2:0] an;

   calc_display_if dut_if ();

   calc_display #(
      .DIV_VARREDURA(DIV),
      .LARGURA      (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .calc_if(dut_if),
      .seg    (seg),
      .an     (an)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   logic [6:0] glifo [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

   int mdl_val  = 0;  // value the display should be showing
   int n_scan   = 0;
   int n_valido = 0;
   bit mon_on   = 0;

   function automatic logic [11:0] ref_bcd(input int v);
      logic [3:0] h, t, u;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   function automatic logic [6:0] ref_seg(input int v, input int idx);
      int d;
      d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
`ifdef CALC_DISPLAY_SUPRIME_ZEROS_EN
      if ((idx == 2 && v < 100) || (idx == 1 && v < 10))
         return 7'b1111111;
`endif
      return glifo[d];
   endfunction

   // Display monitor: digit index follows elapsed cycles since reset release.
   initial begin
      int         idx;
      logic [2:0] exp_an;
      wait (mon_on);
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            n_scan = 0;
            chk("an_rst", 32'(an), 32'(3'b110));
            chk("seg_rst", 32'(seg), 32'(7'b1000000));
         end else begin
            n_scan++;
            idx    = (n_scan / DIV) % 3;
            exp_an = 3'b111;
            exp_an[idx] = 1'b0;
            chk("an_scan", 32'(an), 32'(exp_an));
            chk("seg_digit", 32'(seg), 32'(ref_seg(mdl_val, idx)));
            if (dut_if.bcd_valido === 1'b1) n_valido++;
         end
      end
   end

   // rej: edge (1..8 after acceptance) at which an extra strobe is presented; 0 = none
   task automatic converte(input int v, input int rej);
      int antes;
      int velho;
      antes = n_valido;
      velho = mdl_val;
      @(negedge clk);
      dut_if.resultado = 8'(v);
      dut_if.carregar  = 1'b1;
      @(negedge clk);
      dut_if.carregar  = 1'b0;
      dut_if.resultado = 8'($urandom);
      for (int k = 1; k <= 8; k++) begin
         chk("ocupado_busy", 32'(dut_if.ocupado), 32'd1);
         chk("bcd_hold", 32'(dut_if.bcd), 32'(ref_bcd(velho)));
         chk("valido_busy", 32'(dut_if.bcd_valido), 32'd0);
         dut_if.carregar = (k == rej);
         if (k == rej) dut_if.resultado = 8'($urandom);
         @(negedge clk);
      end
      dut_if.carregar = 1'b0;
      chk("ocupado_done", 32'(dut_if.ocupado), 32'd0);
      chk("bcd_result", 32'(dut_if.bcd), 32'(ref_bcd(v)));
      chk("valido_pulse", 32'(dut_if.bcd_valido), 32'd1);
      mdl_val = v;
      @(negedge clk);
      chk("valido_once", 32'(dut_if.bcd_valido), 32'd0);
      chk("no_requeue", 32'(dut_if.ocupado), 32'd0);
      chk("valido_count", 32'(n_valido - antes), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int antes;
      dut_if.carregar  = 1'b0;
      dut_if.resultado = '0;
      #1 rst_n = 1'b0;
      mon_on = 1;
      #1;
      chk("ocupado_rst", 32'(dut_if.ocupado), 32'd0);
      chk("bcd_rst", 32'(dut_if.bcd), 32'd0);
      chk("valido_rst", 32'(dut_if.bcd_valido), 32'd0);
      chk("an_rst0", 32'(an), 32'(3'b110));
      chk("seg_rst0", 32'(seg), 32'(7'b1000000));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (14) @(negedge clk);

      converte(255, 0);
      converte(0, 0);
      converte(9, 0);
      converte(100, 0);
      converte(37, 3);
      converte(7, 8);
      repeat (14) @(negedge clk);

      // reset in the middle of converting 128
      antes = n_valido;
      @(negedge clk);
      dut_if.resultado = 8'd128;
      dut_if.carregar  = 1'b1;
      @(negedge clk);
      dut_if.carregar  = 1'b0;
      repeat (4) @(negedge clk);
      rst_n   = 1'b0;
      mdl_val = 0;
      #1;
      chk("abort_ocupado", 32'(dut_if.ocupado), 32'd0);
      chk("abort_bcd", 32'(dut_if.bcd), 32'd0);
      chk("abort_valido", 32'(dut_if.bcd_valido), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_idle", 32'(dut_if.ocupado), 32'd0);
      chk("abort_bcd_idle", 32'(dut_if.bcd), 32'd0);
      chk("abort_no_pulse", 32'(n_valido - antes), 32'd0);

      for (int i = 0; i < 40; i++) begin
         converte(int'($urandom_range(0, 255)), int'($urandom_range(0, 8)));
         repeat ($urandom_range(0, 13)) @(negedge clk);
      end
      repeat (14) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
